// File: rtl/instrdec_pkg.sv
// instrdec_pkg: sequencer state encoding and decoder opcode constants shared by sequencer, decoder and bench
package instrdec_pkg;
    typedef enum logic [1:0] {IDLE, FETCH, DECODE, EXEC} state_t;
    localparam logic [3:0] OPR_NOP = 4'b0000;
    localparam logic [3:0] OPR_ADD = 4'b1000;
    localparam logic [3:0] OPR_SUB = 4'b1001;
    localparam logic [3:0] OPR_LD  = 4'b1010;
    localparam logic [3:0] OPR_ACC = 4'b1111;
endpackage

// File: rtl/instr_sequencer_if.sv
// instr_sequencer_if: instruction-memory req/ack fetch bus between sequencer (master) and memory (slave)
interface instr_sequencer_if #(parameter int PC_W = 8);
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_ack;
    logic [7:0]      imem_data;
    modport master (output imem_req, imem_addr, input imem_ack, imem_data);
    modport slave  (input imem_req, imem_addr, output imem_ack, imem_data);
endinterface

// File: rtl/instr_sequencer.sv
// instr_sequencer: fetch/decode/execute controller for the 4-bit decoder; fetch timeout enabled by SEQ_TIMEOUT_EN
module instr_sequencer
    import instrdec_pkg::*;
#(
    parameter int PC_W    = 8,
    parameter int CNT_W   = 16,
    parameter int TMO_CYC = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              step,
    input  logic              halt,
    instr_sequencer_if.master imem,
    output logic [3:0]        opr,
    output logic [3:0]        opa,
    output logic              exec_en,
    input  logic              exec_stall,
    output logic              busy,
    output logic [CNT_W-1:0]  instr_cnt,
    output logic              err
);
    state_t           state_q;
    logic [PC_W-1:0]  pc_q;
    logic [3:0]       opr_q, opa_q;
    logic             req_q, exen_q, hp_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tmo_hit, start_ok, stop;
    assign cnt_d = &cnt_q ? cnt_q : cnt_q + 1'b1;
    assign stop  = hp_q | halt | step;
`ifdef SEQ_TIMEOUT_EN
    logic [3:0] tmo_q;
    logic       err_q;
    assign tmo_hit  = tmo_q == 4'(TMO_CYC - 1);
    assign start_ok = start & ~err_q;
    assign err      = err_q;
    // count consecutive unacknowledged FETCH cycles; err stays set until reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= (state_q == FETCH && !imem.imem_ack && !tmo_hit) ? tmo_q + 4'd1 : '0;
            if (state_q == FETCH && !imem.imem_ack && tmo_hit) err_q <= 1'b1;
        end
    end
`else
    assign tmo_hit  = TMO_CYC < 0;
    assign start_ok = start;
    assign err      = 1'b0;
`endif
    // sequencing FSM; fetch request and commit strobe are registered alongside the state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            opr_q   <= OPR_NOP;
            opa_q   <= '0;
            req_q   <= 1'b0;
            exen_q  <= 1'b0;
            hp_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: if (start_ok && !halt) begin
                    state_q <= FETCH;
                    req_q   <= 1'b1;
                end
                FETCH: if (imem.imem_ack) begin
                    opr_q   <= imem.imem_data[7:4];
                    opa_q   <= imem.imem_data[3:0];
                    pc_q    <= pc_q + 1'b1;
                    hp_q    <= halt;
                    req_q   <= 1'b0;
                    state_q <= DECODE;
                end else if (halt || tmo_hit) begin
                    req_q   <= 1'b0;
                    state_q <= IDLE;
                end
                DECODE: begin
                    hp_q    <= hp_q | halt;
                    exen_q  <= 1'b1;
                    state_q <= EXEC;
                end
                EXEC: if (exec_stall) begin
                    hp_q <= hp_q | halt;
                end else begin
                    cnt_q   <= cnt_d;
                    exen_q  <= 1'b0;
                    hp_q    <= 1'b0;
                    req_q   <= !stop;
                    state_q <= stop ? IDLE : FETCH;
                end
            endcase
        end
    end
    assign imem.imem_req  = req_q;
    assign imem.imem_addr = pc_q;
    assign opr            = opr_q;
    assign opa            = opa_q;
    assign exec_en        = exen_q;
    assign busy           = state_q != IDLE;
    assign instr_cnt      = cnt_q;
endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: randomized scoreboard bench for instr_sequencer with a memory responder and a transaction-level control model
module tb_instr_sequencer;
    import instrdec_pkg::*;
    localparam int PC_W  = 8;
    localparam int CNT_W = 6;
    localparam int TMO   = 15;
    localparam int CMAX  = (1 << CNT_W) - 1;
`ifdef SEQ_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif
    logic clk = 1'b0;
    logic reset, start, step, halt, exec_stall, exec_en, busy, err;
    logic [3:0] opr, opa;
    logic [CNT_W-1:0] instr_cnt;
    instr_sequencer_if #(.PC_W(PC_W)) imem_bus ();
    instr_sequencer #(.PC_W(PC_W), .CNT_W(CNT_W), .TMO_CYC(TMO)) dut (
        .clk(clk), .reset(reset), .start(start), .step(step), .halt(halt), .imem(imem_bus),
        .opr(opr), .opa(opa), .exec_en(exec_en), .exec_stall(exec_stall), .busy(busy),
        .instr_cnt(instr_cnt), .err(err)
    );
    always #5 clk = ~clk;
    int checks = 0, failures = 0;
    logic [7:0] mem [256];
    logic [7:0] sbq [$];
    logic [PC_W-1:0] mpc;
    int mcnt, retired, wmode, wcnt, fcnt;
    bit merr, stall_en, have_exp, in_dec, nd, hseen;
    logic [2:0] exp3;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask
    // memory model: acks after a chosen number of wait cycles and records the expected instruction
    always @(negedge clk) begin
        exec_stall = stall_en && ($urandom_range(2) == 0);
        if (reset) mpc = '0;
        if (reset || !imem_bus.imem_req) begin
            imem_bus.imem_ack  = 1'b0;
            imem_bus.imem_data = 8'($urandom);
            wcnt = (wmode < 0) ? $urandom_range(3) : wmode;
        end else if (wcnt == 0) begin
            imem_bus.imem_ack  = 1'b1;
            imem_bus.imem_data = mem[imem_bus.imem_addr];
            chk("fetch_addr", imem_bus.imem_addr, mpc);
            sbq.push_back(mem[mpc]);
            mpc++;
        end else begin
            imem_bus.imem_ack  = 1'b0;
            imem_bus.imem_data = 8'($urandom);
            wcnt--;
        end
    end
    // monitor: predicts next-cycle {imem_req,busy,exec_en} and checks every retired instruction
    always @(negedge clk) begin
        logic [7:0] e;
        #1;
        if (reset) begin
            have_exp = 0; in_dec = 0; hseen = 0; fcnt = 0; mcnt = 0; merr = 0;
            sbq.delete();
        end else begin
            if (have_exp) chk("ctrl_req_busy_exec", {imem_bus.imem_req, busy, exec_en}, exp3);
            have_exp = 1;
            nd = 0;
            if (!busy) begin
                chk("err", err, merr);
                exp3 = (start && !halt && !merr) ? 3'b110 : 3'b000;
            end else if (imem_bus.imem_req) begin
                if (imem_bus.imem_ack) begin
                    hseen = halt; nd = 1; fcnt = 0; exp3 = 3'b010;
                end else begin
                    fcnt++;
                    if (TMO_EN && fcnt == TMO) merr = 1;
                    exp3 = (halt || (TMO_EN && fcnt == TMO)) ? 3'b000 : 3'b110;
                    if (exp3 == 3'b000) fcnt = 0;
                end
            end else if (in_dec) begin
                hseen = hseen | halt;
                exp3 = 3'b011;
            end else if (exec_en) begin
                hseen = hseen | halt;
                if (exec_stall) exp3 = 3'b011;
                else begin
                    if (sbq.size() == 0) chk("scoreboard_nonempty", 0, 1);
                    else begin
                        e = sbq.pop_front();
                        chk("opr", opr, e[7:4]);
                        chk("opa", opa, e[3:0]);
                    end
                    chk("instr_cnt", instr_cnt, mcnt);
                    if (mcnt < CMAX) mcnt++;
                    retired++;
                    exp3 = (hseen || halt || step) ? 3'b000 : 3'b110;
                    hseen = 0;
                end
            end else have_exp = 0;
            in_dec = nd;
        end
    end
    task automatic wait_idle(input string nm);
        for (int i = 0; i < 100 && busy; i++) begin
            @(negedge clk); #2;
        end
        if (busy) chk(nm, busy, 0);
    endtask
    task automatic set_mode(input int w, input bit s);
        @(negedge clk); wmode = w; stall_en = s;
        @(negedge clk);
    endtask
    task automatic stop_seq();
        @(negedge clk); halt = 1; start = 0; step = 0; #2;
        wait_idle("stop_timeout");
        @(negedge clk); halt = 0; #2;
    endtask
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        int r0, rq, ak, n, k;
        logic [16:1] pat, epat;
        bit ib;
        reset = 1; start = 0; step = 0; halt = 0; wmode = 0; stall_en = 0; retired = 0;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h00; mem[1] = 8'h82; mem[2] = 8'h92; mem[3] = 8'hA0; mem[4] = 8'hF0;
        repeat (2) @(negedge clk);
        #2;
        chk("rst_busy_req_exec", {busy, imem_bus.imem_req, exec_en}, 0);
        chk("rst_opr_opa", {opr, opa}, {OPR_NOP, 4'h0});
        chk("rst_cnt_err_pc", {instr_cnt, err, imem_bus.imem_addr}, 0);
        @(negedge clk); reset = 0; start = 1;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (i == 15) begin halt = 1; start = 0; end
            #2;
            pat[i] = exec_en;
            epat[i] = (i % 3 == 0) && (i < 16);
        end
        @(negedge clk); halt = 0; #2;
        chk("rom_exec_pattern", pat, epat);
        chk("rom_cnt5", instr_cnt, 5);
        chk("rom_idle", busy, 0);
        chk("rom_pc5", imem_bus.imem_addr, 5);
        set_mode(3, 0);
        @(negedge clk); start = 1; #2;
        r0 = retired; rq = 0; ak = 0;
        for (int i = 0; i < 200 && retired < r0 + 3; i++) begin
            @(negedge clk); #2;
            rq += int'(imem_bus.imem_req);
            ak += int'(imem_bus.imem_req && imem_bus.imem_ack);
        end
        chk("wait4_req_cycles", rq, 12);
        chk("wait4_acks", ak, 3);
        stop_seq();
        set_mode(5, 0);
        @(negedge clk); start = 1; #2;
        for (int i = 0; i < 20 && !imem_bus.imem_req; i++) begin @(negedge clk); #2; end
        @(negedge clk); halt = 1; start = 0; #2;
        @(negedge clk); halt = 0; #2;
        chk("halt_fetch_idle", {busy, imem_bus.imem_req}, 0);
        chk("halt_fetch_pc", imem_bus.imem_addr, mpc);
        set_mode(0, 0);
        @(negedge clk); start = 1; #2;
        for (int i = 0; i < 20 && !(imem_bus.imem_req && imem_bus.imem_ack); i++) begin @(negedge clk); #2; end
        @(negedge clk); halt = 1; start = 0; #2;
        n = 0;
        @(negedge clk); halt = 0; #2;
        n += int'(exec_en);
        repeat (5) begin @(negedge clk); #2; n += int'(exec_en); end
        chk("halt_decode_exec_cycles", n, 1);
        chk("halt_decode_idle", busy, 0);
        @(negedge clk); step = 1; #2;
        r0 = retired;
        repeat (2) begin
            @(negedge clk); start = 1; #2;
            @(negedge clk); start = 0; #2;
            wait_idle("step_timeout");
            ib = 0;
            repeat (3) begin @(negedge clk); #2; ib |= busy; end
            chk("step_stays_idle", ib, 0);
        end
        chk("step_retired", retired - r0, 2);
        chk("step_cnt", instr_cnt, mcnt);
        @(negedge clk); start = 1; #2;
        for (int i = 0; i < 10 && !busy; i++) begin @(negedge clk); #2; end
        wait_idle("step_hold_timeout");
        k = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #2; k++;
            if (busy) break;
        end
        chk("step_idle_gap", k, 1);
        stop_seq();
        set_mode(-1, 1);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            start = ($urandom_range(7) != 0);
            halt  = ($urandom_range(39) == 0);
            step  = ($urandom_range(29) == 0);
        end
        stop_seq();
        set_mode(0, 0);
        #2;
        chk("final_cnt", instr_cnt, mcnt);
        chk("final_sb_empty", sbq.size(), 0);
        chk("final_pc", imem_bus.imem_addr, mpc);
`ifdef SEQ_TIMEOUT_EN
        set_mode(1000, 0);
        @(negedge clk); start = 1;
        repeat (20) @(negedge clk);
        #2;
        chk("tmo_err", err, 1);
        chk("tmo_idle", busy, 0);
        @(negedge clk); reset = 1; start = 0; #2;
        chk("tmo_err_cleared", err, 0);
        @(negedge clk); reset = 0;
        set_mode(0, 0);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
